// File: rtl/dec_pkg.sv
// Shared types and helpers for the dec_scan one-hot decoder/scanner.
// Sized for the largest legal select width; users truncate to their own W.
package dec_pkg;

  localparam int MAX_N = 8;
  localparam int MAX_W = 1 << MAX_N;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/dec_scan_tick_div.sv
// Scan-rate prescaler: counts 0..DIV-1 while enabled; tick marks the last count.
// clr restarts the count; a disabled divider holds its position.
module tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dec_scan.sv
// N-to-2^N one-hot decoder with registered output, valid/ready input and an
// autonomous scan mode that walks the active line every DIV cycles.
module dec_scan
  import dec_pkg::*;
#(
  parameter int N          = 4,
  parameter int DIV        = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [N-1:0]        in_sel,
  output logic                in_ready,
  output logic [(1<<N)-1:0]   out,
  output logic                out_valid,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int            W        = 1 << N;
  localparam logic [W-1:0]  INACTIVE = {W{ACTIVE_LOW}};

  state_e       r_state, w_state_nxt;
  logic [N-1:0] r_idx, w_idx_nxt;
  logic [W-1:0] r_out, w_out_nxt;
  logic         r_vld, w_vld_nxt;
  logic         r_wrap, w_wrap_nxt;
  logic         w_clr, w_cnt_en, w_tick;

  tick_div #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .en   (w_cnt_en),
    .tick (w_tick)
  );

  assign in_ready = en && (mode == MODE_DECODE) && (r_state != SCAN);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_vld_nxt   = r_vld;
    w_wrap_nxt  = 1'b0;
    w_clr       = 1'b0;
    w_cnt_en    = 1'b0;

    // Disable parks the block but keeps idx and prescaler where they were.
    if (!en) begin
      w_state_nxt = IDLE;
      w_vld_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        IDLE, HOLD: begin
          if (mode == MODE_SCAN) begin
            w_state_nxt = SCAN;
            w_idx_nxt   = '0;
            w_vld_nxt   = 1'b1;
            w_clr       = 1'b1;
          end else if (in_valid) begin
            w_state_nxt = HOLD;
            w_idx_nxt   = in_sel;
            w_vld_nxt   = 1'b1;
          end
        end
        SCAN: begin
          if (mode != MODE_SCAN) begin
            w_state_nxt = HOLD;
            w_clr       = 1'b1;
          end else begin
            w_cnt_en = 1'b1;
            if (w_tick) begin
              w_idx_nxt  = r_idx + 1'b1;
              w_wrap_nxt = &r_idx;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_vld_nxt   = 1'b0;
        end
      endcase
    end

    w_out_nxt = w_vld_nxt ? (W'(onehot(MAX_N'(w_idx_nxt))) ^ INACTIVE) : INACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_vld   <= 1'b0;
      r_wrap  <= 1'b0;
      r_out   <= INACTIVE;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_vld   <= w_vld_nxt;
      r_wrap  <= w_wrap_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign out       = r_out;
  assign out_valid = r_vld;
  assign idx       = r_idx;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan: the driver queues hand-derived expectations
// stamped with the edge they belong to; a negedge monitor pops and compares.
module tb_dec_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: N=4, DIV=3
  logic        en0, mode0, v0, rdy0, vld0, wrap0;
  logic [3:0]  s0, idx0;
  logic [15:0] out0;
  // DUT1: N=2, DIV=1
  logic        en1, mode1, v1, rdy1, vld1, wrap1;
  logic [1:0]  s1, idx1;
  logic [3:0]  out1;
  // DUT2: N=2, DIV=3, ACTIVE_LOW
  logic        en2, mode2, v2, rdy2, vld2, wrap2;
  logic [1:0]  s2, idx2;
  logic [3:0]  out2;

  dec_scan #(.N(4), .DIV(3), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en0), .mode(mode0), .in_valid(v0), .in_sel(s0),
    .in_ready(rdy0), .out(out0), .out_valid(vld0), .idx(idx0), .wrap(wrap0));

  dec_scan #(.N(2), .DIV(1), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .in_valid(v1), .in_sel(s1),
    .in_ready(rdy1), .out(out1), .out_valid(vld1), .idx(idx1), .wrap(wrap1));

  dec_scan #(.N(2), .DIV(3), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst(rst), .en(en2), .mode(mode2), .in_valid(v2), .in_sel(s2),
    .in_ready(rdy2), .out(out2), .out_valid(vld2), .idx(idx2), .wrap(wrap2));

  typedef struct {
    int unsigned cyc;
    int          dut;
    string       name;
    logic [15:0] out;
    logic        vld;
    logic [3:0]  idx;
    logic        wrap;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input int d, input string nm, input logic [15:0] o,
                      input logic v, input logic [3:0] i, input logic w);
    exp_t e;
    e.cyc  = cyc + 1;
    e.dut  = d;
    e.name = nm;
    e.out  = o;
    e.vld  = v;
    e.idx  = i;
    e.wrap = w;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation whose edge has already happened.
  always @(negedge clk) begin
    exp_t        e;
    logic [21:0] act, want;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.dut)
        0:       act = {out0, vld0, idx0, wrap0};
        1:       act = {12'h000, out1, vld1, 2'b00, idx1, wrap1};
        default: act = {12'h000, out2, vld2, 2'b00, idx2, wrap2};
      endcase
      want = {e.out, e.vld, e.idx, e.wrap};
      n_checks++;
      if (act == want) n_pass++;
      else $display("FAIL %s dut%0d @cyc %0d: got out=%h vld=%b idx=%0d wrap=%b, want out=%h vld=%b idx=%0d wrap=%b",
                    e.name, e.dut, cyc, act[21:6], act[5], act[4:1], act[0],
                    want[21:6], want[5], want[4:1], want[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int e_idx;
    rst = 1'b1;
    en0 = 1'b1; mode0 = 1'b1; v0 = 1'b0; s0 = '0;
    en1 = 1'b0; mode1 = 1'b0; v1 = 1'b0; s1 = '0;
    en2 = 1'b0; mode2 = 1'b0; v2 = 1'b0; s2 = '0;

    // Reset held two cycles with en=1, mode=1
    push(0, "rst_a", 16'h0000, 1'b0, 4'd0, 1'b0);
    push(1, "rst_u1", 16'h0000, 1'b0, 4'd0, 1'b0);
    push(2, "rst_u2_al", 16'h000F, 1'b0, 4'd0, 1'b0);
    #1 chk("rdy_in_rst_a", rdy0, 0);
    step();
    push(0, "rst_b", 16'h0000, 1'b0, 4'd0, 1'b0);
    chk("rdy_in_rst_b", rdy0, 0);
    step();
    rst = 1'b0; mode0 = 1'b0;
    push(0, "idle", 16'h0000, 1'b0, 4'd0, 1'b0);
    #1 chk("rdy_idle", rdy0, 1);

    // Back-to-back decode
    step();
    v0 = 1'b1; s0 = 4'd5;
    push(0, "dec5", 16'h0020, 1'b1, 4'd5, 1'b0);
    step();
    s0 = 4'd15;
    push(0, "dec15", 16'h8000, 1'b1, 4'd15, 1'b0);
    step();
    v0 = 1'b0;
    push(0, "hold15", 16'h8000, 1'b1, 4'd15, 1'b0);

    // Scan entry from HOLD with a competing in_valid that must be ignored
    step();
    mode0 = 1'b1; v0 = 1'b1; s0 = 4'd9;
    #1 chk("rdy_mode_wins", rdy0, 0);
    for (int i = 0; i < 70; i++) begin
      e_idx = (i / 3) % 16;
      push(0, "scan", 16'h0001 << e_idx, 1'b1, 4'(e_idx), (i == 48));
      step();
      chk("rdy_scan", rdy0, 0);
    end

    // Leave scan at idx 7 -> HOLD, then decode in_sel=2
    mode0 = 1'b0; v0 = 1'b0;
    push(0, "scan_exit", 16'h0080, 1'b1, 4'd7, 1'b0);
    #1 chk("rdy_exit_cycle", rdy0, 0);
    step();
    push(0, "hold7", 16'h0080, 1'b1, 4'd7, 1'b0);
    #1 chk("rdy_hold7", rdy0, 1);
    step();
    v0 = 1'b1; s0 = 4'd2;
    push(0, "dec2", 16'h0004, 1'b1, 4'd2, 1'b0);
    step();

    // Scan to idx 10 (second cycle of it), then disable
    v0 = 1'b0; mode0 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      e_idx = (i / 3) % 16;
      push(0, "scan2", 16'h0001 << e_idx, 1'b1, 4'(e_idx), 1'b0);
      step();
    end
    en0 = 1'b0;
    push(0, "en_off", 16'h0000, 1'b0, 4'd10, 1'b0);
    step();
    push(0, "en_off2", 16'h0000, 1'b0, 4'd10, 1'b0);
    step();

    // Re-enable in scan: restarts at 0 with a fresh prescaler
    en0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e_idx = i / 3;
      push(0, "rescan", 16'h0001 << e_idx, 1'b1, 4'(e_idx), 1'b0);
      step();
    end
    rst = 1'b1;
    push(0, "rst_mid", 16'h0000, 1'b0, 4'd0, 1'b0);
    step();
    rst = 1'b0; en0 = 1'b0;
    push(0, "post_rst", 16'h0000, 1'b0, 4'd0, 1'b0);
    step();

    // DIV=1, N=2: advance every cycle, wrap every 4
    en1 = 1'b1; mode1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      e_idx = i % 4;
      push(1, "div1", 16'h0001 << e_idx, 1'b1, 4'(e_idx), (i == 4) || (i == 8));
      step();
    end
    en1 = 1'b0;

    // ACTIVE_LOW decode
    en2 = 1'b1; mode2 = 1'b0; v2 = 1'b1; s2 = 2'd0;
    push(2, "al_sel0", 16'h000E, 1'b1, 4'd0, 1'b0);
    step();
    s2 = 2'd3;
    push(2, "al_sel3", 16'h0007, 1'b1, 4'd3, 1'b0);
    step();
    v2 = 1'b0; en2 = 1'b0;
    push(2, "al_off", 16'h000F, 1'b0, 4'd3, 1'b0);
    step();
    step();
    step();

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
